// File: rtl/modulation_sequencer_if.sv
// Bus bundle between the modulation sequencer and its host/datapath.
// master: the host side (drives requests, observes sequencing outputs).
// slave : the sequencer itself.
interface modulation_sequencer_if #(
  parameter int IDX_W = 8,
  parameter int MOD_W = 15,
  parameter int DIV_W = 16
) ();
  logic             UPDATE;
  logic [MOD_W-1:0] MOD_CYCLE;
  logic [DIV_W-1:0] FREQ_DIV;
  logic             CLR_OVERRUN;
  logic             START;
  logic [IDX_W-1:0] TR_IDX;
  logic             TR_VALID;
  logic             DONE;
  logic [MOD_W-1:0] MOD_IDX;
  logic             BUSY;
  logic             OVERRUN;

  modport master (
    output UPDATE, MOD_CYCLE, FREQ_DIV, CLR_OVERRUN,
    input  START, TR_IDX, TR_VALID, DONE, MOD_IDX, BUSY, OVERRUN
  );

  modport slave (
    input  UPDATE, MOD_CYCLE, FREQ_DIV, CLR_OVERRUN,
    output START, TR_IDX, TR_VALID, DONE, MOD_IDX, BUSY, OVERRUN
  );
endinterface

// File: rtl/modulation_sequencer.sv
// Sequencer for the double-buffered modulation datapath.
// Each UPDATE produces START, a walk of transducer indices 0..DEPTH-1 into
// the multiplier pipeline, a MUL_LATENCY drain, then a DONE commit pulse.
// The modulation sample index steps once every FREQ_DIV completed runs.
// Optional macro MODULATION_SEQUENCER_QUEUE_EN: one-deep pending request
// so an UPDATE arriving mid-run is replayed right after FIN.
module modulation_sequencer #(
  parameter int DEPTH       = 249,
  parameter int MUL_LATENCY = 3,
  parameter int IDX_W       = 8,
  parameter int MOD_W       = 15,
  parameter int DIV_W       = 16
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  modulation_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_RUN,
    S_DRAIN,
    S_FIN
  } state_t;

  localparam int               DRN_W    = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [DRN_W-1:0] LAST_DRN = DRN_W'(MUL_LATENCY - 1);

  state_t           state_q, state_d;
  logic             start_q, start_d;
  logic             done_q, done_d;
  logic             tr_valid_q, tr_valid_d;
  logic [IDX_W-1:0] tr_idx_q, tr_idx_d;
  logic             busy_q, busy_d;
  logic             overrun_q, overrun_d;
  logic [MOD_W-1:0] mod_idx_q, mod_idx_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [DIV_W-1:0] fdiv_sh_q, fdiv_sh_d;
  logic [MOD_W-1:0] mcyc_sh_q, mcyc_sh_d;
  logic [DRN_W-1:0] drain_q, drain_d;
  logic [DIV_W-1:0] div_eff;
  logic             overrun_set;
`ifdef MODULATION_SEQUENCER_QUEUE_EN
  logic             pending_q, pending_d;
`endif

  // A divide ratio of 0 behaves exactly like 1 (step every run).
  assign div_eff = (fdiv_sh_q == '0) ? DIV_W'(1) : fdiv_sh_q;

  // Next-state and registered-output computation for the run sequencer.
  always_comb begin
    state_d     = state_q;
    start_d     = 1'b0;
    done_d      = 1'b0;
    tr_valid_d  = 1'b0;
    tr_idx_d    = tr_idx_q;
    busy_d      = busy_q;
    mod_idx_d   = mod_idx_q;
    div_cnt_d   = div_cnt_q;
    fdiv_sh_d   = fdiv_sh_q;
    mcyc_sh_d   = mcyc_sh_q;
    drain_d     = drain_q;
    overrun_set = 1'b0;
`ifdef MODULATION_SEQUENCER_QUEUE_EN
    pending_d   = pending_q;
`endif

    // A request arriving while a run is in flight (ARM..FIN) cannot start now.
    if (bus.UPDATE && busy_q) begin
`ifdef MODULATION_SEQUENCER_QUEUE_EN
      if (!pending_q) pending_d = 1'b1;
      else            overrun_set = 1'b1;
`else
      overrun_set = 1'b1;
`endif
    end

    unique case (state_q)
      S_IDLE: begin
        if (bus.UPDATE) begin
          state_d = S_ARM;
          start_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      S_ARM: begin
        // Shadow the rate controls so mid-run edits wait for the next run.
        fdiv_sh_d  = bus.FREQ_DIV;
        mcyc_sh_d  = bus.MOD_CYCLE;
        state_d    = S_RUN;
        tr_valid_d = 1'b1;
        tr_idx_d   = '0;
      end
      S_RUN: begin
        if (tr_idx_q == LAST_IDX) begin
          state_d = S_DRAIN;
          drain_d = '0;
        end else begin
          tr_valid_d = 1'b1;
          tr_idx_d   = tr_idx_q + IDX_W'(1);
        end
      end
      S_DRAIN: begin
        if (drain_q == LAST_DRN) begin
          state_d = S_FIN;
          done_d  = 1'b1;
        end else begin
          drain_d = drain_q + DRN_W'(1);
        end
      end
      S_FIN: begin
        // Sample index advances only once the commit has been issued.
        if (div_cnt_q >= div_eff - DIV_W'(1)) begin
          div_cnt_d = '0;
          mod_idx_d = (mod_idx_q >= mcyc_sh_q) ? '0 : mod_idx_q + MOD_W'(1);
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
`ifdef MODULATION_SEQUENCER_QUEUE_EN
        // A held request (or one landing right now) re-arms without an idle gap.
        if (pending_q || bus.UPDATE) begin
          state_d   = S_ARM;
          start_d   = 1'b1;
          busy_d    = 1'b1;
          pending_d = 1'b0;
        end else begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
`else
        state_d = S_IDLE;
        busy_d  = 1'b0;
`endif
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // Set has priority over clear so a lost request is never hidden.
    if (overrun_set)          overrun_d = 1'b1;
    else if (bus.CLR_OVERRUN) overrun_d = 1'b0;
    else                      overrun_d = overrun_q;
  end

  // State and output registers; reset drops every output immediately.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= S_IDLE;
      start_q    <= 1'b0;
      done_q     <= 1'b0;
      tr_valid_q <= 1'b0;
      tr_idx_q   <= '0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
      mod_idx_q  <= '0;
      div_cnt_q  <= '0;
      fdiv_sh_q  <= '0;
      mcyc_sh_q  <= '0;
      drain_q    <= '0;
`ifdef MODULATION_SEQUENCER_QUEUE_EN
      pending_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      start_q    <= start_d;
      done_q     <= done_d;
      tr_valid_q <= tr_valid_d;
      tr_idx_q   <= tr_idx_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
      mod_idx_q  <= mod_idx_d;
      div_cnt_q  <= div_cnt_d;
      fdiv_sh_q  <= fdiv_sh_d;
      mcyc_sh_q  <= mcyc_sh_d;
      drain_q    <= drain_d;
`ifdef MODULATION_SEQUENCER_QUEUE_EN
      pending_q  <= pending_d;
`endif
    end
  end

  assign bus.START    = start_q;
  assign bus.DONE     = done_q;
  assign bus.TR_VALID = tr_valid_q;
  assign bus.TR_IDX   = tr_idx_q;
  assign bus.BUSY     = busy_q;
  assign bus.OVERRUN  = overrun_q;
  assign bus.MOD_IDX  = mod_idx_q;

endmodule

// File: tb/tb_modulation_sequencer.sv
// Scoreboard bench for modulation_sequencer: a timestamp-based reference
// model schedules expected START/TR/DONE events when requests are accepted;
// a negedge monitor matches them against the DUT pulses.
module tb_modulation_sequencer;
  localparam int DEPTH = 249;
  localparam int ML    = 3;
  localparam int IDX_W = 8;
  localparam int MOD_W = 15;
  localparam int DIV_W = 16;
`ifdef MODULATION_SEQUENCER_QUEUE_EN
  localparam bit QUEUE_EN = 1'b1;
`else
  localparam bit QUEUE_EN = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST_N;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  modulation_sequencer_if #(.IDX_W(IDX_W), .MOD_W(MOD_W), .DIV_W(DIV_W)) bus ();

  modulation_sequencer #(
    .DEPTH(DEPTH), .MUL_LATENCY(ML), .IDX_W(IDX_W), .MOD_W(MOD_W), .DIV_W(DIV_W)
  ) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {int c; int idx;} tr_ev_t;
  int     start_q[$];
  int     done_q[$];
  tr_ev_t tr_q[$];
  int     start_rd = 0, tr_rd = 0, done_rd = 0, done_seen = 0;

  // reference model state (written only by the model process)
  int m_active = 0, m_arm = 0, m_fin = -1, m_pend = 0;
  int m_mod = 0, m_cnt = 0, m_shdiv = 0, m_shcyc = 0, m_eff = 1;
  bit m_ovset = 0;
  bit exp_busy = 0, exp_ov = 0;
  int exp_mod = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name, input longint act, input longint exp);
    checks++;
    errors++;
    $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // schedule every observable event of a run whose ARM cycle is a
  task automatic new_run(input int a);
    start_q.push_back(a);
    for (int i = 0; i < DEPTH; i++) tr_q.push_back('{a + 1 + i, i});
    done_q.push_back(a + 1 + DEPTH + ML);
    m_arm    = a;
    m_fin    = a + 1 + DEPTH + ML;
    m_active = 1;
  endtask

  // reference model: inputs of the cycle ending at this edge
  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_active = 0; m_pend = 0; m_mod = 0; m_cnt = 0; m_fin = -1;
      exp_busy = 0; exp_ov = 0; exp_mod = 0;
    end else begin
      m_ovset = 0;
      if (m_active != 0 && cyc == m_arm) begin
        m_shdiv = int'(bus.FREQ_DIV);
        m_shcyc = int'(bus.MOD_CYCLE);
      end
      if (bus.UPDATE) begin
        if (!(m_active != 0 && cyc >= m_arm && cyc <= m_fin)) new_run(cyc + 1);
        else if (QUEUE_EN && m_pend == 0) m_pend = 1;
        else m_ovset = 1;
      end
      if (m_active != 0 && cyc == m_fin) begin
        m_eff = (m_shdiv == 0) ? 1 : m_shdiv;
        if (m_cnt >= m_eff - 1) begin
          m_cnt = 0;
          m_mod = (m_mod >= m_shcyc) ? 0 : m_mod + 1;
        end else begin
          m_cnt++;
        end
        if (m_pend != 0) begin
          m_pend = 0;
          new_run(cyc + 1);
        end else begin
          m_active = 0;
        end
      end
      exp_ov   = m_ovset ? 1'b1 : (bus.CLR_OVERRUN ? 1'b0 : exp_ov);
      exp_busy = (m_active != 0) && (cyc + 1 >= m_arm) && (cyc + 1 <= m_fin);
      exp_mod  = m_mod;
    end
  end

  // monitor: compare DUT outputs against the scoreboard mid-cycle
  always @(negedge CLK) begin
    if (!RST_N) begin
      chk("reset_outputs", {bus.START, bus.TR_VALID, bus.DONE, bus.BUSY, bus.OVERRUN,
                            bus.TR_IDX, bus.MOD_IDX}, 0);
      start_rd = start_q.size();
      tr_rd    = tr_q.size();
      done_rd  = done_q.size();
    end else begin
      chk("busy", bus.BUSY, exp_busy);
      chk("overrun", bus.OVERRUN, exp_ov);
      chk("mod_idx", bus.MOD_IDX, exp_mod);
      if (bus.START && bus.DONE) fail("start_and_done", 1, 0);
      if (bus.START) begin
        if (start_rd < start_q.size()) begin
          chk("start_cycle", cyc, start_q[start_rd]);
          start_rd++;
        end else fail("start_unexpected", 1, 0);
      end else if (start_rd < start_q.size() && start_q[start_rd] < cyc) begin
        fail("start_missing", 0, start_q[start_rd]);
        start_rd++;
      end
      if (bus.TR_VALID) begin
        if (tr_rd < tr_q.size()) begin
          chk("tr_cycle", cyc, tr_q[tr_rd].c);
          chk("tr_idx", bus.TR_IDX, tr_q[tr_rd].idx);
          tr_rd++;
        end else fail("tr_unexpected", 1, 0);
      end else if (tr_rd < tr_q.size() && tr_q[tr_rd].c < cyc) begin
        fail("tr_missing", 0, tr_q[tr_rd].c);
        tr_rd++;
      end
      if (bus.DONE) begin
        done_seen++;
        if (done_rd < done_q.size()) begin
          chk("done_cycle", cyc, done_q[done_rd]);
          done_rd++;
        end else fail("done_unexpected", 1, 0);
      end else if (done_rd < done_q.size() && done_q[done_rd] < cyc) begin
        fail("done_missing", 0, done_q[done_rd]);
        done_rd++;
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_update();
    bus.UPDATE = 1'b1;
    tick();
    bus.UPDATE = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    tick();
    while (bus.BUSY && n < 2000) begin
      tick();
      n++;
    end
    if (n >= 2000) fail("idle_timeout", n, 2000);
    tick();
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    repeat (2) tick();
    RST_N = 1'b1;
    tick();
  endtask

  int seq_exp[10] = '{0, 0, 1, 1, 1, 2, 2, 2, 0, 0};
  int d0;

  initial begin
    RST_N = 1'b0;
    bus.UPDATE = 1'b0;
    bus.CLR_OVERRUN = 1'b0;
    bus.FREQ_DIV = '0;
    bus.MOD_CYCLE = '0;
    repeat (3) tick();
    RST_N = 1'b1;

    // single run with UPDATE at cycle 10
    bus.FREQ_DIV = 16'd1;
    bus.MOD_CYCLE = 15'd4;
    while (cyc < 10) tick();
    d0 = done_seen;
    pulse_update();
    wait_idle();
    chk("single_run_dones", done_seen - d0, 1);
    chk("single_run_mod", bus.MOD_IDX, 1);

    // divide-by-3 wrap at 2 over ten runs
    do_reset();
    bus.FREQ_DIV = 16'd3;
    bus.MOD_CYCLE = 15'd2;
    for (int i = 0; i < 10; i++) begin
      pulse_update();
      wait_idle();
      chk("div3_seq", bus.MOD_IDX, seq_exp[i]);
    end

    // FREQ_DIV = 0 steps every run
    do_reset();
    bus.FREQ_DIV = 16'd0;
    bus.MOD_CYCLE = 15'd7;
    for (int i = 0; i < 3; i++) begin
      pulse_update();
      wait_idle();
      chk("div0_seq", bus.MOD_IDX, i + 1);
    end

    // MOD_CYCLE shrinks below the current index mid-run
    do_reset();
    bus.FREQ_DIV = 16'd1;
    bus.MOD_CYCLE = 15'd10;
    for (int i = 0; i < 5; i++) begin
      pulse_update();
      wait_idle();
    end
    chk("mod_at_5", bus.MOD_IDX, 5);
    pulse_update();
    repeat (20) tick();
    bus.MOD_CYCLE = 15'd3;
    wait_idle();
    chk("shrink_same_run", bus.MOD_IDX, 6);
    pulse_update();
    wait_idle();
    chk("shrink_next_run", bus.MOD_IDX, 0);

    // MOD_CYCLE = 0 pins the index
    bus.MOD_CYCLE = 15'd0;
    for (int i = 0; i < 2; i++) begin
      pulse_update();
      wait_idle();
      chk("mod_cycle0", bus.MOD_IDX, 0);
    end

    // second UPDATE 100 cycles into a run, then a third one
    bus.MOD_CYCLE = 15'd5;
    d0 = done_seen;
    pulse_update();
    repeat (99) tick();
    pulse_update();
    chk("ov_second_pulse", bus.OVERRUN, QUEUE_EN ? 0 : 1);
    repeat (48) tick();
    pulse_update();
    chk("ov_third_pulse", bus.OVERRUN, 1);
    wait_idle();
    chk("double_dones", done_seen - d0, QUEUE_EN ? 2 : 1);
    bus.CLR_OVERRUN = 1'b1;
    tick();
    bus.CLR_OVERRUN = 1'b0;
    chk("ov_cleared", bus.OVERRUN, 0);

    // set beats clear when they coincide
    pulse_update();
    repeat (10) tick();
    if (QUEUE_EN) pulse_update();
    bus.UPDATE = 1'b1;
    bus.CLR_OVERRUN = 1'b1;
    tick();
    bus.UPDATE = 1'b0;
    bus.CLR_OVERRUN = 1'b0;
    chk("ov_set_wins", bus.OVERRUN, 1);
    wait_idle();

    // randomized runs with mid-run disturbances
    for (int r = 0; r < 20; r++) begin
      bus.FREQ_DIV = 16'($urandom_range(0, 3));
      bus.MOD_CYCLE = 15'($urandom_range(0, 6));
      pulse_update();
      for (int k = 0; k < DEPTH + 8; k++) begin
        case ($urandom_range(0, 299))
          0: pulse_update();
          1: begin bus.CLR_OVERRUN = 1'b1; tick(); bus.CLR_OVERRUN = 1'b0; end
          2: begin
            bus.FREQ_DIV = 16'($urandom_range(0, 3));
            bus.MOD_CYCLE = 15'($urandom_range(0, 6));
            tick();
          end
          default: tick();
        endcase
      end
      wait_idle();
    end

    // reset 50 cycles into a run: no DONE, fresh run afterwards
    bus.FREQ_DIV = 16'd1;
    bus.MOD_CYCLE = 15'd9;
    d0 = done_seen;
    pulse_update();
    repeat (49) tick();
    RST_N = 1'b0;
    repeat (2) tick();
    RST_N = 1'b1;
    repeat (300) tick();
    chk("reset_no_done", done_seen - d0, 0);
    chk("reset_mod_zero", bus.MOD_IDX, 0);
    pulse_update();
    wait_idle();
    chk("after_reset_dones", done_seen - d0, 1);
    chk("after_reset_mod", bus.MOD_IDX, 1);

    repeat (5) tick();
    chk("left_start", start_q.size() - start_rd, 0);
    chk("left_tr", tr_q.size() - tr_rd, 0);
    chk("left_done", done_q.size() - done_rd, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
